// File: rtl/issue_ctrl.sv
// In-order issue controller: circular instruction queue, RV32I head decoder and
// dispatch to ROB + RS/LSB. Optional dispatch stall counter under ISSUE_STALL_CNT_EN.

module decoder (
  input  logic [31:0] inst,
  output logic [5:0]  inst_name,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [31:0] imm,
  output logic        is_store,
  output logic        jump
);
  localparam logic [5:0] NOP = 6'd0;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'd0};
  assign imm_j  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  // Codes: 1 LUI,2 AUIPC,3 JAL,4 JALR,5-10 branches,11-15 loads,16-18 stores,
  // 19-27 OP-IMM, 28-37 OP. jump flags any control transfer (branch or jump).
  always_comb begin
    inst_name = NOP;
    rd        = 5'd0;
    rs1       = 5'd0;
    rs2       = 5'd0;
    imm       = 32'd0;
    is_store  = 1'b0;
    jump      = 1'b0;
    case (opcode)
      7'b0110111: begin inst_name = 6'd1; rd = inst[11:7]; imm = imm_u; end
      7'b0010111: begin inst_name = 6'd2; rd = inst[11:7]; imm = imm_u; end
      7'b1101111: begin inst_name = 6'd3; rd = inst[11:7]; imm = imm_j; jump = 1'b1; end
      7'b1100111: if (funct3 == 3'b000) begin
        inst_name = 6'd4; rd = inst[11:7]; rs1 = inst[19:15]; imm = imm_i; jump = 1'b1;
      end
      7'b1100011: begin
        case (funct3)
          3'b000:  inst_name = 6'd5;
          3'b001:  inst_name = 6'd6;
          3'b100:  inst_name = 6'd7;
          3'b101:  inst_name = 6'd8;
          3'b110:  inst_name = 6'd9;
          3'b111:  inst_name = 6'd10;
          default: inst_name = NOP;
        endcase
        rs1 = inst[19:15]; rs2 = inst[24:20]; imm = imm_b; jump = 1'b1;
      end
      7'b0000011: begin
        case (funct3)
          3'b000:  inst_name = 6'd11;
          3'b001:  inst_name = 6'd12;
          3'b010:  inst_name = 6'd13;
          3'b100:  inst_name = 6'd14;
          3'b101:  inst_name = 6'd15;
          default: inst_name = NOP;
        endcase
        rd = inst[11:7]; rs1 = inst[19:15]; imm = imm_i;
      end
      7'b0100011: begin
        case (funct3)
          3'b000:  inst_name = 6'd16;
          3'b001:  inst_name = 6'd17;
          3'b010:  inst_name = 6'd18;
          default: inst_name = NOP;
        endcase
        rs1 = inst[19:15]; rs2 = inst[24:20]; imm = imm_s; is_store = 1'b1;
      end
      7'b0010011: begin
        case (funct3)
          3'b000:  inst_name = 6'd19;
          3'b010:  inst_name = 6'd20;
          3'b011:  inst_name = 6'd21;
          3'b100:  inst_name = 6'd22;
          3'b110:  inst_name = 6'd23;
          3'b111:  inst_name = 6'd24;
          3'b001:  inst_name = (funct7 == 7'b0000000) ? 6'd25 : NOP;
          3'b101:  inst_name = (funct7 == 7'b0000000) ? 6'd26 :
                               (funct7 == 7'b0100000) ? 6'd27 : NOP;
          default: inst_name = NOP;
        endcase
        rd = inst[11:7]; rs1 = inst[19:15]; imm = imm_i;
      end
      7'b0110011: begin
        case ({funct7, funct3})
          10'b0000000_000: inst_name = 6'd28;
          10'b0100000_000: inst_name = 6'd29;
          10'b0000000_001: inst_name = 6'd30;
          10'b0000000_010: inst_name = 6'd31;
          10'b0000000_011: inst_name = 6'd32;
          10'b0000000_100: inst_name = 6'd33;
          10'b0000000_101: inst_name = 6'd34;
          10'b0100000_101: inst_name = 6'd35;
          10'b0000000_110: inst_name = 6'd36;
          10'b0000000_111: inst_name = 6'd37;
          default:         inst_name = NOP;
        endcase
        rd = inst[11:7]; rs1 = inst[19:15]; rs2 = inst[24:20];
      end
      default: inst_name = NOP;
    endcase
    // Unknown encodings carry no operands so a drop never leaks stale fields.
    if (inst_name == NOP) begin
      rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd0; is_store = 1'b0; jump = 1'b0;
    end
  end
endmodule

module issue_ctrl #(
  parameter int IQ_DEPTH  = 16,
  parameter int IQ_ADDR_W = 4,
  parameter int ROB_TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clr,
  input  logic                 if_valid,
  input  logic [31:0]          if_inst,
  input  logic [31:0]          if_pc,
  input  logic                 if_pred_jump,
  output logic                 iq_full,
  input  logic                 rob_full,
  input  logic                 rs_full,
  input  logic                 lsb_full,
  input  logic [ROB_TAG_W-1:0] rob_tag,
  output logic                 to_rob_valid,
  output logic                 to_rs_valid,
  output logic                 to_lsb_valid,
  output logic [5:0]           out_inst_name,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [31:0]          out_imm,
  output logic [31:0]          out_pc,
  output logic                 out_pred_jump,
  output logic                 out_is_store,
  output logic                 out_jump,
  output logic [ROB_TAG_W-1:0] out_tag,
  output logic [31:0]          stall_cnt
);
  localparam logic [IQ_ADDR_W:0] FULL_CNT = (IQ_ADDR_W+1)'(IQ_DEPTH);

  logic [IQ_DEPTH-1:0][31:0] inst_q;
  logic [IQ_DEPTH-1:0][31:0] pc_q;
  logic [IQ_DEPTH-1:0]       pred_q;
  logic [IQ_ADDR_W-1:0]      head, tail;
  logic [IQ_ADDR_W:0]        count;

  logic [5:0]  d_name;
  logic [4:0]  d_rd, d_rs1, d_rs2;
  logic [31:0] d_imm;
  logic        d_store, d_jump;
  logic        nonempty, is_nop, is_lsb, blocked, push, pop, dispatch;
  logic [6:0]  head_op;

  decoder u_dec (
    .inst      (inst_q[head]),
    .inst_name (d_name),
    .rd        (d_rd),
    .rs1       (d_rs1),
    .rs2       (d_rs2),
    .imm       (d_imm),
    .is_store  (d_store),
    .jump      (d_jump)
  );

  assign head_op  = inst_q[head][6:0];
  assign iq_full  = (count == FULL_CNT);
  assign nonempty = (count != '0);
  assign is_nop   = (d_name == 6'd0);
  assign is_lsb   = (head_op == 7'b0000011) || (head_op == 7'b0100011);
  // Drops need no ROB slot and no target, so they are never blocked.
  assign blocked  = !is_nop && (rob_full || (is_lsb ? lsb_full : rs_full));
  assign push     = rdy && !clr && if_valid && !iq_full;
  assign pop      = rdy && !clr && nonempty && !blocked;
  assign dispatch = pop && !is_nop;

  always_ff @(posedge clk) begin
    if (push) begin
      inst_q[tail] <= if_inst;
      pc_q[tail]   <= if_pc;
      pred_q[tail] <= if_pred_jump;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      to_rob_valid  <= 1'b0;
      to_rs_valid   <= 1'b0;
      to_lsb_valid  <= 1'b0;
      out_inst_name <= '0;
      out_rd        <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_imm       <= '0;
      out_pc        <= '0;
      out_pred_jump <= 1'b0;
      out_is_store  <= 1'b0;
      out_jump      <= 1'b0;
      out_tag       <= '0;
    end else if (!rdy) begin
      to_rob_valid <= 1'b0;
      to_rs_valid  <= 1'b0;
      to_lsb_valid <= 1'b0;
    end else if (clr) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      to_rob_valid <= 1'b0;
      to_rs_valid  <= 1'b0;
      to_lsb_valid <= 1'b0;
    end else begin
      to_rob_valid <= dispatch;
      to_rs_valid  <= dispatch && !is_lsb;
      to_lsb_valid <= dispatch && is_lsb;
      if (push) tail <= tail + IQ_ADDR_W'(1);
      if (pop)  head <= head + IQ_ADDR_W'(1);
      if (push && !pop)      count <= count + (IQ_ADDR_W+1)'(1);
      else if (pop && !push) count <= count - (IQ_ADDR_W+1)'(1);
      if (dispatch) begin
        out_inst_name <= d_name;
        out_rd        <= d_rd;
        out_rs1       <= d_rs1;
        out_rs2       <= d_rs2;
        out_imm       <= d_imm;
        out_pc        <= pc_q[head];
        out_pred_jump <= pred_q[head];
        out_is_store  <= d_store;
        out_jump      <= d_jump;
        out_tag       <= rob_tag;
      end
    end
  end

`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else if (rdy && !clr && nonempty && blocked) stall_q <= stall_q + 32'd1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_issue_ctrl.sv
// Randomized + directed bench for issue_ctrl: instructions are built by an
// encoder that records the expected decode, and a queue model predicts dispatch.

module tb_issue_ctrl;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
    logic [5:0]  name;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        store, jump, lsb, nop;
  } ent_t;

`ifdef ISSUE_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk = 0, rst, rdy, clr, if_valid, if_pred_jump;
  logic [31:0] if_inst, if_pc;
  logic        rob_full, rs_full, lsb_full;
  logic [3:0]  rob_tag;
  logic        iq_full, to_rob_valid, to_rs_valid, to_lsb_valid;
  logic [5:0]  out_inst_name;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm, out_pc, stall_cnt;
  logic        out_pred_jump, out_is_store, out_jump;
  logic [3:0]  out_tag;

  issue_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .if_valid(if_valid), .if_inst(if_inst),
    .if_pc(if_pc), .if_pred_jump(if_pred_jump), .iq_full(iq_full), .rob_full(rob_full),
    .rs_full(rs_full), .lsb_full(lsb_full), .rob_tag(rob_tag), .to_rob_valid(to_rob_valid),
    .to_rs_valid(to_rs_valid), .to_lsb_valid(to_lsb_valid), .out_inst_name(out_inst_name),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm), .out_pc(out_pc),
    .out_pred_jump(out_pred_jump), .out_is_store(out_is_store), .out_jump(out_jump),
    .out_tag(out_tag), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int          n_checks = 0, n_fail = 0;
  ent_t        q[$];
  ent_t        exp_p;
  logic [3:0]  e_tag;
  logic [31:0] e_stall, pc_ctr;
  logic        e_rob, e_rs, e_lsb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t raw(input logic [31:0] inst, input logic [5:0] name,
                               input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [31:0] imm, input logic store, input logic jump,
                               input logic lsb);
    ent_t e = '0;
    e.inst = inst; e.name = name; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
    e.store = store; e.jump = jump; e.lsb = lsb; e.nop = (name == 6'd0);
    return e;
  endfunction

  // Encode an instruction of the given kind and record what it must decode to.
  function automatic ent_t mk(input int kind, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] r);
    logic [31:0] si = {{20{r[11]}}, r[11:0]};
    logic [31:0] sb = {{19{r[12]}}, r[12:1], 1'b0};
    logic [31:0] sj = {{11{r[20]}}, r[20:1], 1'b0};
    case (kind)
      0:  return raw({r[11:0], rs1, 3'd0, rd, 7'h13}, 6'd19, rd, rs1, 5'd0, si, 0, 0, 0);
      1:  return raw({r[11:0], rs1, 3'd7, rd, 7'h13}, 6'd24, rd, rs1, 5'd0, si, 0, 0, 0);
      2:  return raw({7'h00, rs2, rs1, 3'd0, rd, 7'h33}, 6'd28, rd, rs1, rs2, 32'd0, 0, 0, 0);
      3:  return raw({7'h20, rs2, rs1, 3'd0, rd, 7'h33}, 6'd29, rd, rs1, rs2, 32'd0, 0, 0, 0);
      4:  return raw({r[11:0], rs1, 3'd2, rd, 7'h03}, 6'd13, rd, rs1, 5'd0, si, 0, 0, 1);
      5:  return raw({r[11:0], rs1, 3'd0, rd, 7'h03}, 6'd11, rd, rs1, 5'd0, si, 0, 0, 1);
      6:  return raw({r[11:5], rs2, rs1, 3'd2, r[4:0], 7'h23}, 6'd18, 5'd0, rs1, rs2, si, 1, 0, 1);
      7:  return raw({r[11:5], rs2, rs1, 3'd0, r[4:0], 7'h23}, 6'd16, 5'd0, rs1, rs2, si, 1, 0, 1);
      8:  return raw({r[12], r[10:5], rs2, rs1, 3'd0, r[4:1], r[11], 7'h63}, 6'd5,
                     5'd0, rs1, rs2, sb, 0, 1, 0);
      9:  return raw({r[20], r[10:1], r[11], r[19:12], rd, 7'h6f}, 6'd3, rd, 5'd0, 5'd0, sj, 0, 1, 0);
      10: return raw({r[31:12], rd, 7'h37}, 6'd1, rd, 5'd0, 5'd0, {r[31:12], 12'd0}, 0, 0, 0);
      11: return raw({r[11:0], rs1, 3'd0, rd, 7'h67}, 6'd4, rd, rs1, 5'd0, si, 0, 1, 0);
      default: return raw({r[31:7], 7'h7f}, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 0, 0);
    endcase
  endfunction

  function automatic ent_t rnd_ent();
    return mk($urandom_range(0, 12), 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
  endfunction

  // One clock: predict from the model, drive, clock, compare every output.
  task automatic step(input logic v, input ent_t e_in);
    ent_t e = e_in, h;
    int   sz = q.size();
    e.pc = pc_ctr; e.pred = 1'($urandom);
    if (v) pc_ctr += 4;
    if_valid = v; if_inst = e.inst; if_pc = e.pc; if_pred_jump = e.pred;
    e_rob = 0; e_rs = 0; e_lsb = 0;
    if (rst) begin
      q.delete(); exp_p = '0; e_tag = '0; e_stall = '0;
    end else if (rdy && clr) begin
      q.delete();
    end else if (rdy) begin
      if (sz > 0) begin
        h = q[0];
        if (h.nop) void'(q.pop_front());
        else if (rob_full || (h.lsb ? lsb_full : rs_full)) begin
          if (STALL_EN) e_stall++;
        end else begin
          void'(q.pop_front());
          e_rob = 1; e_rs = !h.lsb; e_lsb = h.lsb; exp_p = h; e_tag = rob_tag;
        end
      end
      if (v && sz < 16) q.push_back(e);
    end
    @(posedge clk); #1;
    chk("to_rob_valid", 64'(to_rob_valid), 64'(e_rob));
    chk("to_rs_valid", 64'(to_rs_valid), 64'(e_rs));
    chk("to_lsb_valid", 64'(to_lsb_valid), 64'(e_lsb));
    chk("iq_full", 64'(iq_full), 64'(q.size() == 16));
    chk("out_inst_name", 64'(out_inst_name), 64'(exp_p.name));
    chk("out_regs", 64'({out_rd, out_rs1, out_rs2}), 64'({exp_p.rd, exp_p.rs1, exp_p.rs2}));
    chk("out_imm", 64'(out_imm), 64'(exp_p.imm));
    chk("out_pc", 64'(out_pc), 64'(exp_p.pc));
    chk("out_flags", 64'({out_pred_jump, out_is_store, out_jump}),
        64'({exp_p.pred, exp_p.store, exp_p.jump}));
    chk("out_tag", 64'(out_tag), 64'(e_tag));
    chk("stall_cnt", 64'(stall_cnt), 64'(e_stall));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  initial begin
    rst = 1; rdy = 1; clr = 0; rob_full = 0; rs_full = 0; lsb_full = 0; rob_tag = 0;
    if_valid = 0; if_inst = 0; if_pc = 0; if_pred_jump = 0; pc_ctr = 32'h1000;
    exp_p = '0; e_tag = '0; e_stall = '0;
    // reset state
    step(1'b0, '0);
    rst = 0;

    // ALU dispatch: addi x1,x0,5 with tag 3
    rob_tag = 4'd3;
    step(1'b1, raw(32'h00500093, 6'd19, 5'd1, 5'd0, 5'd0, 32'd5, 0, 0, 0));
    idle(2);

    // Load/store routing
    rob_tag = 4'd7;
    step(1'b1, raw(32'h0040A183, 6'd13, 5'd3, 5'd1, 5'd0, 32'd4, 0, 0, 1));
    step(1'b1, raw(32'h0020A423, 6'd18, 5'd0, 5'd1, 5'd2, 32'd8, 1, 0, 1));
    idle(3);

    // Full and wrap: 17 offers with RS blocked, then drain
    rs_full = 1;
    for (int i = 0; i < 17; i++) step(1'b1, mk(0, 5'(i), 5'(i + 1), 5'd0, 32'(i * 3)));
    rs_full = 0;
    for (int i = 0; i < 18; i++) begin rob_tag = 4'(i); step(1'b0, '0); end

    // Stall counter: lw held by lsb_full for 5 cycles
    step(1'b1, mk(4, 5'd5, 5'd6, 5'd0, 32'd12));
    lsb_full = 1;
    idle(5);
    lsb_full = 0;
    idle(2);

    // Flush: 4 queued behind rob_full, clr with a simultaneous push
    rob_full = 1;
    for (int i = 0; i < 4; i++) step(1'b1, mk(2, 5'(i), 5'd1, 5'd2, 32'd0));
    clr = 1;
    step(1'b1, mk(0, 5'd9, 5'd9, 5'd0, 32'd9));
    clr = 0; rob_full = 0;
    idle(3);

    // Reset mid-operation
    rob_full = 1;
    for (int i = 0; i < 4; i++) step(1'b1, mk(5, 5'(i), 5'd3, 5'd0, 32'(-i)));
    rst = 1;
    step(1'b0, '0);
    rst = 0; rob_full = 0;
    idle(3);

    // rdy low for 3 cycles with a queued addi
    step(1'b1, mk(0, 5'd4, 5'd2, 5'd0, 32'd100));
    rdy = 0;
    step(1'b1, mk(1, 5'd1, 5'd1, 5'd0, 32'd1));
    idle(2);
    rdy = 1;
    idle(2);

    // Drop: all-zero word is popped without a strobe
    step(1'b1, raw(32'h00000000, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 0, 0));
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      clr      = ($urandom_range(0, 39) == 0);
      rdy      = ($urandom_range(0, 9) != 0);
      rob_full = ($urandom_range(0, 5) == 0);
      rs_full  = ($urandom_range(0, 4) == 0);
      lsb_full = ($urandom_range(0, 4) == 0);
      rob_tag  = 4'($urandom);
      step(1'($urandom_range(0, 9) < 7), rnd_ent());
    end
    rst = 0; clr = 0; rdy = 1; rob_full = 0; rs_full = 0; lsb_full = 0;
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
